// File: rtl/opb_reg_pkg.sv
// rtl/opb_reg_pkg.sv - register offsets, status bit positions and ack FSM states
package opb_reg_pkg;

    localparam logic [5:0] OFF_DATA   = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;
    localparam logic [5:0] OFF_COUNT  = 6'd2;

    localparam int ST_NEW = 0;
    localparam int ST_OVF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RECOVER = 2'd2
    } ack_state_e;

    function automatic logic [31:0] status_word(input logic new_flag, input logic ovf_flag);
        logic [31:0] w;
        w         = '0;
        w[ST_NEW] = new_flag;
        w[ST_OVF] = ovf_flag;
        return w;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - OPB window decode and IDLE/ACK/RECOVER acknowledge FSM
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_4100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_41FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic                    select,
    input  logic                    rnw,
    output logic                    rd_strobe,
    output logic                    wr_strobe,
    output logic [5:0]              offset,
    output logic                    ack
);

    ack_state_e state_q, state_d;
    logic       ack_q, ack_d;
    logic       hit;

    assign hit    = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign offset = abus[24:29];

    // Strobes fire only from IDLE, so they coincide with the edge that raises ack.
    assign rd_strobe = (state_q == IDLE) && hit && rnw;
    assign wr_strobe = (state_q == IDLE) && hit && !rnw;
    assign ack       = ack_q;

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK:     state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// rtl/opb_register_simulink2ppc.sv - fabric-to-PPC capture register with status and count over OPB
module opb_register_simulink2ppc
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_4100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_41FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid
);

    localparam string UNUSED_FAMILY = C_FAMILY;

    logic        rd_strobe, wr_strobe;
    logic [5:0]  offset;
    logic        ack;

    logic [31:0] shadow_q, shadow_d;
    logic        new_q, new_d;
    logic        ovf_q, ovf_d;
    logic [31:0] count_q, count_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        new_clr, ovf_set, ovf_clr;
    logic        unused_ok;

    assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], OPB_DBus[31]};

    opb_slave_ack_fsm #(
        .C_BASEADDR  (C_BASEADDR),
        .C_HIGHADDR  (C_HIGHADDR),
        .C_OPB_AWIDTH(C_OPB_AWIDTH)
    ) u_ack_fsm (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .abus     (OPB_ABus),
        .select   (OPB_select),
        .rnw      (OPB_RNW),
        .rd_strobe(rd_strobe),
        .wr_strobe(wr_strobe),
        .offset   (offset),
        .ack      (ack)
    );

    // A capture on the same edge as a DATA read keeps NEW set and never flags overflow.
    always_comb begin
        new_clr  = rd_strobe && (offset == OFF_DATA);
        ovf_set  = user_valid && new_q && !new_clr;
        ovf_clr  = wr_strobe && (offset == OFF_STATUS) && OPB_BE[3] && OPB_DBus[30];

        shadow_d = user_valid ? user_data_in : shadow_q;
        new_d    = user_valid ? 1'b1 : (new_clr ? 1'b0 : new_q);
        ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        count_d  = count_q + {31'd0, user_valid};
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_strobe) begin
            case (offset)
                OFF_DATA:   rd_data_d = shadow_q;
                OFF_STATUS: rd_data_d = status_word(new_q, ovf_q);
                OFF_COUNT:  rd_data_d = count_q;
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            shadow_q  <= '0;
            new_q     <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            new_q     <= new_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign Sl_DBus    = rd_data_q;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule
